ieee754_sp_mul_pipe: RTL and testbench



---
 rtl/ieee754_sp_mul_pipe.sv | 123 ++++++++++++
 tb/tb_ieee754_sp_mul_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ieee754_sp_mul_pipe.sv
// Pipelined binary32 multiplier c = a * b, round-toward-zero; `FMUL_DENORM_EN keeps denormals, else DAZ/FTZ.
// Latency: a/b sampled at edge N appear on c after edge N+3; one operand pair accepted per cycle.
// Backpressure: none; operands are taken every cycle and results stream out unconditionally.
module ieee754_sp_mul_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    // All-zero encoding is SP_ZERO so reset bubbles drain out as +0.
    typedef enum logic [1:0] {
        SP_ZERO = 2'd0,
        SP_NONE = 2'd1,
        SP_INF  = 2'd2,
        SP_NAN  = 2'd3
    } spec_t;

    logic [7:0]         ea, eb, ea_eff, eb_eff;
    logic [22:0]        fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    spec_t              sp1_d, sp1_q, sp2_q, sp3_q;
    logic               s1_d, s1_q, s2_q, s3_q;
    logic [23:0]        sa1_d, sb1_d, sa1_q, sb1_q;
    logic signed [9:0]  e1_d, e1_q, e2_q, e3_d, e3_q;
    logic [47:0]        p2_d, p2_q;
    logic [5:0]         lz;
    logic [23:0]        m3_d, m3_q;
    logic [31:0]        c_d, c_q;

    function automatic logic [5:0] lzc48(input logic [47:0] v);
        lzc48 = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (v[i]) lzc48 = 6'(47 - i);
        end
    endfunction

    assign ea = a[30:23];
    assign eb = b[30:23];
    assign fa = a[22:0];
    assign fb = b[22:0];

    // Stage 1: unpack and classify.
    always_comb begin
        a_nan  = (ea == 8'hFF) && (fa != 23'h0);
        b_nan  = (eb == 8'hFF) && (fb != 23'h0);
        a_inf  = (ea == 8'hFF) && (fa == 23'h0);
        b_inf  = (eb == 8'hFF) && (fb == 23'h0);
`ifdef FMUL_DENORM_EN
        a_zero = (ea == 8'h00) && (fa == 23'h0);
        b_zero = (eb == 8'h00) && (fb == 23'h0);
        sa1_d  = {(ea != 8'h00), fa};
        sb1_d  = {(eb != 8'h00), fb};
        ea_eff = (ea == 8'h00) ? 8'd1 : ea;
        eb_eff = (eb == 8'h00) ? 8'd1 : eb;
`else
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        sa1_d  = {1'b1, fa};
        sb1_d  = {1'b1, fb};
        ea_eff = ea;
        eb_eff = eb;
`endif
        s1_d = a[31] ^ b[31];
        e1_d = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff}) - 10'sd127;
        if (a_nan || b_nan)                           sp1_d = SP_NAN;
        else if ((a_zero && b_inf) || (a_inf && b_zero)) sp1_d = SP_NAN;
        else if (a_inf || b_inf)                      sp1_d = SP_INF;
        else if (a_zero || b_zero)                    sp1_d = SP_ZERO;
        else                                          sp1_d = SP_NONE;
    end

    // Stage 2: significand product.
    assign p2_d = {24'h0, sa1_q} * {24'h0, sb1_q};

    // Stage 3a: bring the leading one to bit 46, keep hidden bit plus 23 fraction bits.
    always_comb begin
        lz   = lzc48(p2_q);
        m3_d = (lz == 6'd0) ? p2_q[47:24] : 24'((p2_q << (lz - 6'd1)) >> 23);
        e3_d = e2_q + 10'sd1 - $signed({4'b0000, lz});
    end

    // Stage 3b: special-case select, overflow/underflow, pack.
    always_comb begin
        c_d = {s3_q, 31'h0};
        if (sp3_q == SP_NAN) begin
            c_d = 32'h7FC0_0000;
        end else if (sp3_q == SP_INF) begin
            c_d = {s3_q, 8'hFF, 23'h0};
        end else if (sp3_q == SP_ZERO || !m3_q[23]) begin
            c_d = {s3_q, 31'h0};
        end else if (e3_q >= 10'sd255) begin
            c_d = {s3_q, 8'hFF, 23'h0};
        end else if (e3_q <= 10'sd0) begin
`ifdef FMUL_DENORM_EN
            c_d = {s3_q, 8'h00, 23'(m3_q >> (10'sd1 - e3_q))};
`else
            c_d = {s3_q, 31'h0};
`endif
        end else begin
            c_d = {s3_q, e3_q[7:0], m3_q[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp1_q <= SP_ZERO; s1_q <= 1'b0; sa1_q <= '0; sb1_q <= '0; e1_q <= '0;
            sp2_q <= SP_ZERO; s2_q <= 1'b0; p2_q  <= '0; e2_q  <= '0;
            sp3_q <= SP_ZERO; s3_q <= 1'b0; m3_q  <= '0; e3_q  <= '0;
            c_q   <= '0;
        end else begin
            sp1_q <= sp1_d; s1_q <= s1_d; sa1_q <= sa1_d; sb1_q <= sb1_d; e1_q <= e1_d;
            sp2_q <= sp1_q; s2_q <= s1_q; p2_q  <= p2_d;  e2_q  <= e1_q;
            sp3_q <= sp2_q; s3_q <= s2_q; m3_q  <= m3_d;  e3_q  <= e3_d;
            c_q   <= c_d;
        end
    end

    assign c = c_q;

endmodule

// File: tb/tb_ieee754_sp_mul_pipe.sv
// Bench for ieee754_sp_mul_pipe: vector table, back-to-back stream, reset flush and
// randomized operands against a real-arithmetic reference.
module tb_ieee754_sp_mul_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic [31:0] c;

    int checks = 0;
    int errors = 0;

    ieee754_sp_mul_pipe dut (.clk(clk), .rst(rst), .a(a), .b(b), .c(c));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic real fp_mag(input logic [31:0] x);
        int e = int'(x[30:23]);
        int s = int'(x[22:0]);
        if (e == 0) return $itor(s) * pow2(1 - 150);
        return $itor(s + (1 << 23)) * pow2(e - 150);
    endfunction

    // Exact product in double precision, then truncated into binary32.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic sg = x[31] ^ y[31];
        logic xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        logic yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        logic xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        logic yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        logic xz, yz;
        real  p;
        logic [63:0] bits;
        int   se;
        int   f;
`ifdef FMUL_DENORM_EN
        xz = (x[30:0] == 0);
        yz = (y[30:0] == 0);
`else
        xz = (x[30:23] == 0);
        yz = (y[30:23] == 0);
`endif
        if (xn || yn) return 32'h7FC0_0000;
        if ((xz && yi) || (xi && yz)) return 32'h7FC0_0000;
        if (xi || yi) return {sg, 8'hFF, 23'h0};
        if (xz || yz) return {sg, 31'h0};
        p    = fp_mag(x) * fp_mag(y);
        bits = $realtobits(p);
        se   = int'(bits[62:52]) - 1023 + 127;
        if (se >= 255) return {sg, 8'hFF, 23'h0};
        if (se >= 1)   return {sg, se[7:0], bits[51:29]};
`ifdef FMUL_DENORM_EN
        f = $rtoi(p * pow2(149));
        return {sg, 8'h00, f[22:0]};
`else
        f = 0;
        return {sg, 31'h0} | {9'h0, f[22:0]};
`endif
    endfunction

    function automatic logic [31:0] rand_fp();
        logic        s  = 1'($urandom);
        logic [22:0] fr = 23'($urandom);
        case ($urandom_range(0, 9))
            0:       return $urandom;
            1:       return {s, 8'h00, fr};
            2:       return {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'h0 : fr};
            3, 4, 5: return {s, 8'($urandom_range(1, 254)), fr};
            default: return {s, 8'($urandom_range(60, 190)), fr};
        endcase
    endfunction

    vec_t tbl[$];
    logic [31:0] exp_q[$];
    logic [31:0] sa[5];
    logic [31:0] sb[5];

    initial begin
        tbl.push_back('{32'h7F80_0000, 32'h0181_0000, 32'h7F80_0000});
        tbl.push_back('{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000});
        tbl.push_back('{32'h4000_0000, 32'h4200_0000, 32'h4280_0000});
        tbl.push_back('{32'h7B80_0040, 32'h9A21_1080, 32'hD621_10D0});
        tbl.push_back('{32'h7F80_0840, 32'h0000_1688, 32'h7FC0_0000});
        tbl.push_back('{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000});
        tbl.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000});
        tbl.push_back('{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000});
        tbl.push_back('{32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000});
        tbl.push_back('{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000});
        tbl.push_back('{32'h8000_0000, 32'h7FC0_0001, 32'h7FC0_0000});
        tbl.push_back('{32'h0000_0001, 32'h0000_0001, 32'h0000_0000});
`ifdef FMUL_DENORM_EN
        tbl.push_back('{32'h6780_0840, 32'h0001_0680, 32'h2503_4875});
        tbl.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0040_0000});
        tbl.push_back('{32'h8000_0001, 32'h3F80_0000, 32'h8000_0001});
        tbl.push_back('{32'h0000_0001, 32'h4B00_0000, 32'h0080_0000});
`else
        tbl.push_back('{32'h6780_0840, 32'h0001_0680, 32'h0000_0000});
        tbl.push_back('{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000});
        tbl.push_back('{32'h8000_0001, 32'h3F80_0000, 32'h8000_0000});
        tbl.push_back('{32'h0000_0001, 32'h4B00_0000, 32'h0000_0000});
`endif

        tick();
        tick();
        check("reset_c", c, 32'h0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            a = tbl[i].a;
            b = tbl[i].b;
            for (int k = 0; k < 10; k++) tick();
            check($sformatf("vec%0d %08h*%08h", i, tbl[i].a, tbl[i].b), c, tbl[i].c);
        end

        // Back-to-back stream of 5: each result appears 3 edges after its sampling edge.
        sa = '{32'h4000_0000, 32'h3FC0_0000, 32'hC040_0000, 32'h7F80_0000, 32'h4110_0000};
        sb = '{32'h4200_0000, 32'h3FC0_0000, 32'h4080_0000, 32'h0000_0000, 32'hBF00_0000};
        for (int i = 0; i < 8; i++) begin
            if (i < 5) begin
                a = sa[i];
                b = sb[i];
            end
            tick();
            if (i >= 3) check($sformatf("stream%0d", i - 3), c, ref_mul(sa[i - 3], sb[i - 3]));
        end

        // Randomized streaming against the reference model.
        exp_q.delete();
        for (int i = 0; i < 1503; i++) begin
            a = (i < 1500) ? rand_fp() : 32'h0;
            b = (i < 1500) ? rand_fp() : 32'h0;
            exp_q.push_back(ref_mul(a, b));
            tick();
            if (exp_q.size() == 4) check($sformatf("rand%0d", i - 3), c, exp_q.pop_front());
        end

        // Reset flushes in-flight work; pipe refills 3 edges after release.
        a = 32'h7F80_0840;
        b = 32'h0000_1688;
        for (int k = 0; k < 4; k++) tick();
        check("nan_before_rst", c, 32'h7FC0_0000);
        rst = 1'b1;
        a   = 32'h4000_0000;
        b   = 32'h4200_0000;
        tick();
        check("rst_clears", c, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("refill%0d", k), c, 32'h0);
        end
        tick();
        check("refill_done", c, 32'h4280_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
